pattern_playback_controller: RTL and testbench

//   Sequences playback of a stored stimulus pattern (one DATA_W word per sample) out of a synchronous pattern memory.

---
 rtl/pattern_playback_controller_if.sv | 14 +
 rtl/pattern_playback_controller.sv | 145 ++++++++++++++
 tb/tb_pattern_playback_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_playback_controller_if.sv
// pattern_playback_controller_if: synchronous pattern-memory read port (read strobe, address, 1-cycle-latency read data)
//   rd_en  controller -> memory  read strobe
//   addr   controller -> memory  read address
//   rdata  memory -> controller  data for the read issued in the previous cycle
interface pattern_playback_controller_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  modport master (output rd_en, addr, input rdata);
  modport slave (input rd_en, addr, output rdata);
endinterface

// File: rtl/pattern_playback_controller.sv
// pattern_playback_controller: plays a stored pattern out of synchronous memory, one sample every TICK_DIV cycles
//   clk, reset (async, active-high); start/stop pulses; num_samples = pattern length; loop = replay request
//   mem: pattern memory read port (master side of pattern_playback_controller_if)
//   sample_valid/sample_data/sample_index: emitted samples; busy: not idle; done: normal completion pulse
//   Optional feature: define LOOP_PLAYBACK_EN to honour the loop input.
module pattern_playback_controller #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 12,
  parameter int          TICK_DIV  = 5,
  parameter logic [31:0] CNT_START = 32'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [ADDR_W:0]              num_samples,
  input  logic                         loop,
  pattern_playback_controller_if.master mem,
  output logic                         sample_valid,
  output logic [DATA_W-1:0]            sample_data,
  output logic [31:0]                  sample_index,
  output logic                         busy,
  output logic                         done
);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [2:0] {IDLE, PRIME, LOAD, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] n_q, n_d, n_in, pf1;
  logic [ADDR_W-1:0] idx_q, idx_d, pf_idx, addr_q, addr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [31:0] cnt_q, cnt_d, index_q, index_d;
  logic [DATA_W-1:0] buf_q, buf_d, data_q, data_d;
  logic rd_q, rd_d, pend_q, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic last, wrap, enter, loop_en;
`ifdef LOOP_PLAYBACK_EN
  localparam logic LP = 1'b1;
  assign loop_en = loop;
`else
  localparam logic LP = 1'b0;
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en = 1'b0;
`endif
  assign n_in = num_samples[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : num_samples;
  assign last = ({1'b0, idx_q} + (ADDR_W+1)'(1)) == n_q;
  assign wrap = tick_q == TW'(TICK_DIV - 1);
  // index of the sample whose period starts next; also the loop wrap target
  assign pf_idx = (state_q == RUN && !last) ? idx_q + ADDR_W'(1) : '0;
  assign pf1 = {1'b0, pf_idx} + (ADDR_W+1)'(1);
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    idx_d = idx_q;
    tick_d = tick_q;
    cnt_d = cnt_q;
    index_d = index_q;
    data_d = data_q;
    valid_d = 1'b0;
    enter = 1'b0;
    // the single outstanding read always lands in buf one cycle after its strobe
    buf_d = pend_q ? mem.rdata : buf_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        n_d = n_in;
        idx_d = '0;
        cnt_d = CNT_START;
        state_d = (n_in == '0) ? FIN : PRIME;
      end
      PRIME: state_d = LOAD;
      LOAD: begin
        state_d = RUN;
        tick_d = '0;
        enter = 1'b1;
      end
      RUN: begin
        if (tick_q == '0) begin
          valid_d = 1'b1;
          data_d = buf_q;
          index_d = cnt_q;
          cnt_d = cnt_q + 32'd1;
        end
        tick_d = wrap ? '0 : tick_q + TW'(1);
        if (wrap) begin
          idx_d = pf_idx;
          enter = !last || loop_en;
          state_d = enter ? RUN : FIN;
        end
      end
      default: state_d = IDLE;
    endcase
    // prefetch at the start of each period; with looping built in, the last sample always prefetches address 0
    rd_d = (state_d == PRIME) || (enter && (pf1 < n_q || LP));
    addr_d = !rd_d ? addr_q : (enter && pf1 < n_q) ? pf1[ADDR_W-1:0] : '0;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
      rd_d = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      index_d = index_q;
    end
    done_d = state_d == FIN;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      tick_q <= '0;
      cnt_q <= '0;
      index_q <= '0;
      data_q <= '0;
      buf_q <= '0;
      rd_q <= 1'b0;
      addr_q <= '0;
      pend_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      tick_q <= tick_d;
      cnt_q <= cnt_d;
      index_q <= index_d;
      data_q <= data_d;
      buf_q <= buf_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      pend_q <= rd_q;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign mem.rd_en = rd_q;
  assign mem.addr = addr_q;
  assign sample_valid = valid_q;
  assign sample_data = data_q;
  assign sample_index = index_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pattern_playback_controller.sv
// tb_pattern_playback_controller: directed stimulus with a timeline model of playback and literal spot checks
module tb_pattern_playback_controller;
  localparam int TD = 5;
`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP_ON = 1'b1;
`else
  localparam bit LOOP_ON = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [4:0] num_samples = '0;
  logic sample_valid, busy, done;
  logic [15:0] sample_data;
  logic [31:0] sample_index;
  logic [15:0] mem [16];
  int total = 0, bad = 0, cyc = 0;
  int act = 0, t0 = 0, mn = 0, lim = 0, rel, dr, k;
  logic ev, eb, edn, er;
  logic [15:0] ed = '0;
  logic [31:0] ei = '0;
  int t;

  pattern_playback_controller_if #(.DATA_W(16), .ADDR_W(4)) mif ();
  pattern_playback_controller #(.DATA_W(16), .ADDR_W(4), .TICK_DIV(TD), .CNT_START(32'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_samples(num_samples), .loop(loop),
    .mem(mif.master), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_index(sample_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mif.rd_en) mif.rdata <= mem[mif.addr];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // timeline model: a run accepted at cycle t0 emits sample k at t0+4+TD*k, finishes at t0+3+TD*lim
  always @(negedge clk) begin
    rel = cyc - t0;
    dr = (mn == 0) ? 1 : 3 + TD * lim;
    eb = !reset && act != 0 && rel >= 1 && rel <= dr;
    edn = !reset && act != 0 && rel == dr;
    ev = !reset && act != 0 && mn > 0 && rel >= 4 && (rel - 4) % TD == 0 && (rel - 4) / TD < lim;
    er = !reset && act != 0 && mn > 0 &&
         (rel == 1 || (rel >= 3 && (rel - 3) % TD == 0 && (rel - 3) / TD + (LOOP_ON ? 0 : 1) < lim));
    if (reset) begin
      ed = '0;
      ei = '0;
    end else if (ev) begin
      k = (rel - 4) / TD;
      ed = mem[k % mn];
      ei = k;
    end
    chk("sample_valid", {31'd0, sample_valid}, {31'd0, ev});
    chk("busy", {31'd0, busy}, {31'd0, eb});
    chk("done", {31'd0, done}, {31'd0, edn});
    chk("mem_rd_en", {31'd0, mif.rd_en}, {31'd0, er});
    chk("sample_data", {16'd0, sample_data}, {16'd0, ed});
    chk("sample_index", sample_index, ei);
    if (er) chk("mem_addr", {28'd0, mif.addr}, (rel == 1) ? 0 : ((rel - 3) / TD + 1) % mn);
    if (reset) act = 0;
    else begin
      if (LOOP_ON && act != 0 && loop && mn > 0 && rel == 2 + TD * lim) lim += mn;
      if (eb && (stop || rel == dr)) act = 0;
      else if (act == 0 && start && !stop) begin
        act = 1;
        t0 = cyc;
        mn = (num_samples > 16) ? 16 : int'(num_samples);
        lim = mn;
      end
    end
  end

  task automatic at_cyc(input int c);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cyc != c && g < 2000);
    if (cyc != c) begin
      total++;
      bad++;
      $display("FAIL wait_cycle: got %0d expected %0d", cyc, c);
    end
  endtask

  task automatic go(input logic [4:0] n, output int tc);
    @(posedge clk);
    #1 num_samples = n;
    start = 1'b1;
    tc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hA0 + 16'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, sample_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_index", sample_index, 32'd0);
    reset = 1'b0;
    // basic N=4
    go(5'd4, t);
    at_cyc(t + 4);
    chk("basic_first_valid", {31'd0, sample_valid}, 32'd1);
    chk("basic_first_data", {16'd0, sample_data}, 32'hA0);
    at_cyc(t + 19);
    chk("basic_last_data", {16'd0, sample_data}, 32'hA3);
    chk("basic_last_index", sample_index, 32'd3);
    at_cyc(t + 23);
    chk("basic_done", {31'd0, done}, 32'd1);
    at_cyc(t + 24);
    chk("basic_busy_low", {31'd0, busy}, 32'd0);
    // zero length
    go(5'd0, t);
    at_cyc(t + 1);
    chk("zero_done", {31'd0, done}, 32'd1);
    at_cyc(t + 2);
    chk("zero_busy_low", {31'd0, busy}, 32'd0);
    // stop one cycle after the third sample
    go(5'd8, t);
    at_cyc(t + 14);
    chk("stop_third_index", sample_index, 32'd2);
    pulse_stop();
    at_cyc(t + 16);
    chk("stop_busy_low", {31'd0, busy}, 32'd0);
    at_cyc(t + 40);
    chk("stop_hold_data", {16'd0, sample_data}, 32'hA2);
    chk("stop_hold_index", sample_index, 32'd2);
    // start together with stop in IDLE
    @(posedge clk);
    #1 start = 1'b1;
    stop = 1'b1;
    num_samples = 5'd3;
    t = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    stop = 1'b0;
    at_cyc(t + 2);
    chk("startstop_idle", {31'd0, busy}, 32'd0);
    // start during RUN is ignored
    go(5'd5, t);
    at_cyc(t + 8);
    @(posedge clk);
    #1 start = 1'b1;
    num_samples = 5'd2;
    @(posedge clk);
    #1 start = 1'b0;
    at_cyc(t + 24);
    chk("ignore_index4", sample_index, 32'd4);
    at_cyc(t + 28);
    chk("ignore_done", {31'd0, done}, 32'd1);
    // length clamps to memory depth
    go(5'd31, t);
    at_cyc(t + 79);
    chk("clamp_last_data", {16'd0, sample_data}, 32'hAF);
    chk("clamp_last_index", sample_index, 32'd15);
    at_cyc(t + 83);
    chk("clamp_done", {31'd0, done}, 32'd1);
`ifdef LOOP_PLAYBACK_EN
    loop = 1'b1;
    go(5'd3, t);
    at_cyc(t + 19);
    chk("loop_wrap_data", {16'd0, sample_data}, 32'hA0);
    chk("loop_wrap_index", sample_index, 32'd3);
    at_cyc(t + 22);
    @(posedge clk);
    #1 loop = 1'b0;
    at_cyc(t + 29);
    chk("loop_idx5_data", {16'd0, sample_data}, 32'hA2);
    at_cyc(t + 33);
    chk("loop_done", {31'd0, done}, 32'd1);
`else
    loop = 1'b1;
    go(5'd2, t);
    at_cyc(t + 13);
    chk("loop_ignored_done", {31'd0, done}, 32'd1);
    loop = 1'b0;
`endif
    // async reset mid-run, then replay
    go(5'd6, t);
    at_cyc(t + 10);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", {31'd0, sample_valid}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_data", {16'd0, sample_data}, 32'd0);
    chk("areset_index", sample_index, 32'd0);
    chk("areset_rd_en", {31'd0, mif.rd_en}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    go(5'd3, t);
    at_cyc(t + 4);
    chk("replay_valid", {31'd0, sample_valid}, 32'd1);
    chk("replay_index", sample_index, 32'd0);
    chk("replay_data", {16'd0, sample_data}, 32'hA0);
    at_cyc(t + 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
